// File: rtl/c_ctrl_pkg.sv
// Shared state encodings for the stage handshake controller.
// Package name common_param is the one every pipeline stage imports.
package common_param;

  typedef enum logic [1:0] {
    IN_IDLE = 2'd0,
    IN_CAPT = 2'd1,
    IN_ACK  = 2'd2
  } in_state_t;

  typedef enum logic [1:0] {
    OUT_IDLE = 2'd0,
    OUT_REQ  = 2'd1,
    OUT_RTZ  = 2'd2
  } out_state_t;

endpackage

// File: rtl/c_ctrl_if.sv
// Four-phase handshake bundle around one pipeline stage.
// Upstream pair: Send_in / Ack_out. Downstream pair: Send_out / Ack_in.
// CP is the capture enable for the stage's data registers.
interface c_ctrl_if;
  logic Send_in;
  logic Ack_out;
  logic Send_out;
  logic Ack_in;
  logic CP;

  // Environment / neighbouring stages drive the requests and acknowledges
  modport master (
    output Send_in,
    output Ack_in,
    input  Ack_out,
    input  Send_out,
    input  CP
  );

  // The controller itself
  modport slave (
    input  Send_in,
    input  Ack_in,
    output Ack_out,
    output Send_out,
    output CP
  );
endinterface

// File: rtl/c_ctrl.sv
// c_ctrl: clocked handshake controller for one single-token pipeline stage.
// An input FSM captures tokens from upstream, an output FSM offers them
// downstream, and the full flag couples the two. All outputs registered.
// Optional macro C_FASTFWD_EN: allow a new capture on the same edge where
// the downstream acknowledge frees the buffer.
module c_ctrl
  import common_param::*;
(
  input  logic      CLK,
  input  logic      MR,
  c_ctrl_if.slave   hs
);

  in_state_t  in_q,  in_nxt;
  out_state_t out_q, out_nxt;
  logic       full_q, full_nxt;
  logic       cp_q, ack_q, send_q;
  logic       accept;
  logic       room;

  // Next-state logic for both FSMs and the full flag
  always_comb begin
    in_nxt   = in_q;
    out_nxt  = out_q;
    full_nxt = full_q;

    // Downstream takes the token on this edge
    accept = (out_q == OUT_REQ) && hs.Ack_in;
`ifdef C_FASTFWD_EN
    room = !full_q || accept;
`else
    room = !full_q;
`endif

    unique case (in_q)
      IN_IDLE: if (hs.Send_in && room) in_nxt = IN_CAPT;
      IN_CAPT: in_nxt = IN_ACK;
      IN_ACK:  if (!hs.Send_in) in_nxt = IN_IDLE;
      default: in_nxt = IN_IDLE;
    endcase

    unique case (out_q)
      OUT_IDLE: if (full_q) out_nxt = OUT_REQ;
      OUT_REQ:  if (hs.Ack_in) out_nxt = OUT_RTZ;
      OUT_RTZ:  if (!hs.Ack_in) out_nxt = OUT_IDLE;
      default:  out_nxt = OUT_IDLE;
    endcase

    // A token sits in the buffer from the end of CAPT until downstream
    // accepts it; the two never coincide because OUT_REQ implies full.
    if (in_q == IN_CAPT) full_nxt = 1'b1;
    else if (accept)     full_nxt = 1'b0;
  end

  // State, full flag and registered outputs; MR discards any token
  always_ff @(posedge CLK) begin
    if (MR) begin
      in_q   <= IN_IDLE;
      out_q  <= OUT_IDLE;
      full_q <= 1'b0;
      cp_q   <= 1'b0;
      ack_q  <= 1'b0;
      send_q <= 1'b0;
    end else begin
      in_q   <= in_nxt;
      out_q  <= out_nxt;
      full_q <= full_nxt;
      cp_q   <= (in_nxt == IN_CAPT);
      ack_q  <= (in_nxt == IN_ACK);
      send_q <= (out_nxt == OUT_REQ);
    end
  end

  assign hs.CP       = cp_q;
  assign hs.Ack_out  = ack_q;
  assign hs.Send_out = send_q;

endmodule

// File: tb/tb_c_ctrl.sv
// Directed bench for c_ctrl: a vector table of {MR, Send_in, Ack_in} with
// expected {CP, Ack_out, Send_out} after each edge, then a streaming run
// with responsive neighbours. Honours C_FASTFWD_EN in its expectations.
module tb_c_ctrl;

  typedef struct {
    logic mr;
    logic s;
    logic a;
    logic [2:0] exp;   // {CP, Ack_out, Send_out}
  } vec_t;

  localparam int NV = 33;

  logic clk = 1'b0;
  logic mr;
  int   n_vec = 0;
  int   n_err = 0;
  vec_t tbl [NV];

  c_ctrl_if hs ();

  c_ctrl dut (
    .CLK (clk),
    .MR  (mr),
    .hs  (hs)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [5:0] b);
    vec_t v;
    v.mr  = b[5];
    v.s   = b[4];
    v.a   = b[3];
    v.exp = b[2:0];
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  int cp_edges[$];
  int cp_cnt, so_cnt;
  logic so_prev;
  int period;

  initial begin
    //            mr s a  cp ao so
    // reset held with Send_in high
    tbl[0]  = mk(6'b110_000);
    tbl[1]  = mk(6'b110_000);
    // single token
    tbl[2]  = mk(6'b010_100);
    tbl[3]  = mk(6'b010_010);
    tbl[4]  = mk(6'b010_011);
    tbl[5]  = mk(6'b000_001);
    tbl[6]  = mk(6'b001_000);
    tbl[7]  = mk(6'b000_000);
    // backpressure: token buffered, second request waits
    tbl[8]  = mk(6'b010_100);
    tbl[9]  = mk(6'b010_010);
    tbl[10] = mk(6'b000_001);
    tbl[11] = mk(6'b010_001);
    tbl[12] = mk(6'b010_001);
`ifdef C_FASTFWD_EN
    tbl[13] = mk(6'b011_100);
    tbl[14] = mk(6'b011_010);
`else
    tbl[13] = mk(6'b011_000);
    tbl[14] = mk(6'b011_100);
`endif
    // return-to-zero: Ack_in held with new token loaded
    tbl[15] = mk(6'b011_010);
    tbl[16] = mk(6'b011_010);
    tbl[17] = mk(6'b000_000);
    tbl[18] = mk(6'b000_001);
    tbl[19] = mk(6'b001_000);
    tbl[20] = mk(6'b000_000);
    // mid-operation reset, then stale Ack_in
    tbl[21] = mk(6'b010_100);
    tbl[22] = mk(6'b010_010);
    tbl[23] = mk(6'b010_011);
    tbl[24] = mk(6'b110_000);
    tbl[25] = mk(6'b001_000);
    tbl[26] = mk(6'b001_000);
    tbl[27] = mk(6'b000_000);
    // Send_in glitch during CAPT is ignored
    tbl[28] = mk(6'b010_100);
    tbl[29] = mk(6'b000_010);
    tbl[30] = mk(6'b000_001);
    tbl[31] = mk(6'b001_000);
    tbl[32] = mk(6'b000_000);

    mr = 1'b1;
    hs.Send_in = 1'b0;
    hs.Ack_in  = 1'b0;
    #2;

    for (int i = 0; i < NV; i++) begin
      mr         = tbl[i].mr;
      hs.Send_in = tbl[i].s;
      hs.Ack_in  = tbl[i].a;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d {cp,ao,so}", i),
          int'({hs.CP, hs.Ack_out, hs.Send_out}), int'(tbl[i].exp));
    end

    // Streaming with always-responsive neighbours
    cp_cnt  = 0;
    so_cnt  = 0;
    so_prev = 1'b0;
    mr      = 1'b0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      hs.Send_in = !hs.Ack_out && (cp_cnt < 8);
      hs.Ack_in  = hs.Send_out;
      @(posedge clk);
      #1;
      if (hs.CP) begin
        cp_cnt++;
        cp_edges.push_back(cyc);
      end
      if (hs.Send_out && !so_prev) so_cnt++;
      so_prev = hs.Send_out;
    end
`ifdef C_FASTFWD_EN
    period = 3;
`else
    period = 4;
`endif
    chk("stream CP count", cp_cnt, 8);
    chk("stream Send_out count", so_cnt, 8);
    for (int k = 1; k < cp_edges.size(); k++)
      chk($sformatf("stream period %0d", k),
          cp_edges[k] - cp_edges[k-1], period);
    chk("stream idle Send_out", int'(hs.Send_out), 0);
    chk("stream idle Ack_out", int'(hs.Ack_out), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
